// File: rtl/inst_fetch_pkg.sv
// Shared constants, FSM encoding and queue entry layout for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH_DEF = 4;
  localparam logic [WORD_W-1:0] RST_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } state_e;

  // One prefetch queue entry: the fetch address and the word read from it.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundles the instruction-memory port and the core-facing fetch port.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic              imem_re;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_data;
  logic              take;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] meirei;
  logic              meirei_valid;
  logic [WORD_W-1:0] meirei_pc;

  // master: the fetch unit; slave: memory plus core driving it.
  modport master (
    output imem_re, imem_addr, meirei, meirei_valid, meirei_pc,
    input  imem_data, take, redirect, redirect_pc
  );

  modport slave (
    input  imem_re, imem_addr, meirei, meirei_valid, meirei_pc,
    output imem_data, take, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with synchronous flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // Flush wins over both push and pop in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Data storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction prefetch unit: issues single-cycle-latency reads into a small queue and
// presents the head word to the core, with flush-and-refetch on redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH  = DEPTH_DEF,
  parameter logic [WORD_W-1:0] RST_PC = RST_PC_DEF
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] fpc_q, fpc_d;
  logic              inflight_q;
  logic [WORD_W-1:0] inflight_pc_q;
  logic [WORD_W-1:0] hold_inst_q, hold_pc_q;

  logic              issue, push, pop, flush, redirect_act, room;
  logic [AW:0]       count;
  logic              full, empty;
  entry_t            head, push_entry;

  // Credit check counts the outstanding read; a same-cycle take is not credited.
  assign room = ~full & ((count + (AW+1)'(inflight_q)) < (AW+1)'(DEPTH));

  assign push_entry = '{pc: inflight_pc_q, inst: bus.imem_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // FSM next state and per-cycle queue/fetch controls.
  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    redirect_act = 1'b0;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (bus.redirect) begin
          // Returning word is dropped here; SQUASH covers the read slot.
          redirect_act = 1'b1;
          flush        = 1'b1;
          state_d      = inflight_q ? SQUASH : RUN;
        end else begin
          issue = room;
          push  = inflight_q;
          pop   = bus.take & ~empty;
        end
      end
      SQUASH: begin
        if (bus.redirect) begin
          redirect_act = 1'b1;
          flush        = 1'b1;
          state_d      = SQUASH;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch pointer: redirect target, else advance on each issued read.
  always_comb begin
    fpc_d = fpc_q;
    if (redirect_act) begin
      fpc_d = bus.redirect_pc;
    end else if (issue) begin
      fpc_d = fpc_q + 16'd1;
    end
  end

  // State, fetch pointer and outstanding-read tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fpc_q         <= RST_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fpc_q;
    end
  end

  // Shadow of the head so meirei holds its last value once the queue drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
    end else if (!empty) begin
      hold_inst_q <= head.inst;
      hold_pc_q   <= head.pc;
    end
  end

  assign bus.imem_re      = issue;
  assign bus.imem_addr    = issue ? fpc_q : '0;
  assign bus.meirei_valid = ~empty;
  assign bus.meirei       = empty ? hold_inst_q : head.inst;
  assign bus.meirei_pc    = empty ? hold_pc_q : head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: ROM model, expected-read and expected-word queues.
module tb_inst_fetch;

  logic clk;
  logic rst;

  inst_fetch_if bus();

  inst_fetch #(
    .DEPTH  (4),
    .RST_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail = 0;
  int issue_cnt = 0;
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_word_q[$];
  logic [15:0] next_fetch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hA000;
  endfunction

  // Memory with one-cycle read latency.
  always @(posedge clk) bus.imem_data <= bus.imem_re ? rom(bus.imem_addr) : 16'h0BAD;

  task automatic go_edge();
    @(posedge clk);
    #1;
  endtask

  // Sample point of every cycle; checks each issued read against the expected queue.
  task automatic sample();
    logic [15:0] a;
    @(negedge clk);
    if (rst && bus.imem_re) begin
      issue_cnt++;
      n_tests++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_addr: unexpected read at %h, no read required", bus.imem_addr);
      end else begin
        a = exp_addr_q.pop_front();
        if (bus.imem_addr !== a) begin
          n_fail++;
          $display("FAIL read_addr: got %h required %h", bus.imem_addr, a);
        end
      end
    end
  endtask

  task automatic step();
    go_edge();
    sample();
  endtask

  task automatic expect_fetch();
    exp_addr_q.push_back(next_fetch);
    exp_word_q.push_back({next_fetch, rom(next_fetch)});
    next_fetch = next_fetch + 16'd1;
  endtask

  // Wait (bounded) for a word, check it against the scoreboard, then consume it.
  task automatic take_word();
    int w = 0;
    logic [31:0] e;
    while (bus.meirei_valid !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    n_tests++;
    if (bus.meirei_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL take_wait: meirei_valid %b required 1 within 10 cycles", bus.meirei_valid);
      return;
    end
    n_tests++;
    if (exp_word_q.size() == 0) begin
      n_fail++;
      $display("FAIL take_word: word %h presented, none required", bus.meirei);
      return;
    end
    e = exp_word_q.pop_front();
    n_tests++;
    if (bus.meirei_pc !== e[31:16]) begin
      n_fail++;
      $display("FAIL take_pc: got %h required %h", bus.meirei_pc, e[31:16]);
    end
    n_tests++;
    if (bus.meirei !== e[15:0]) begin
      n_fail++;
      $display("FAIL take_inst: got %h required %h", bus.meirei, e[15:0]);
    end
    expect_fetch();
    bus.take = 1'b1;
    go_edge();
    bus.take = 1'b0;
    sample();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    sample();
    n_tests++;
    if (bus.imem_re !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b required 0", bus.imem_re); end
    n_tests++;
    if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h required 0000", bus.imem_addr); end
    n_tests++;
    if (bus.meirei !== 16'h0000) begin n_fail++; $display("FAIL rst_meirei: got %h required 0000", bus.meirei); end
    n_tests++;
    if (bus.meirei_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h required 0000", bus.meirei_pc); end
    n_tests++;
    if (bus.meirei_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", bus.meirei_valid); end
  endtask

  task automatic test_fill();
    next_fetch = 16'h0000;
    repeat (4) expect_fetch();
    go_edge();
    rst = 1'b1;
    sample();
    n_tests++;
    if (bus.imem_re !== 1'b0) begin n_fail++; $display("FAIL fill_c0_re: got %b required 0", bus.imem_re); end
    for (int c = 1; c <= 8; c++) begin
      step();
      n_tests++;
      if (bus.imem_re !== (c <= 4)) begin
        n_fail++;
        $display("FAIL fill_re c%0d: got %b required %b", c, bus.imem_re, (c <= 4));
      end
      n_tests++;
      if (bus.meirei_valid !== (c >= 3)) begin
        n_fail++;
        $display("FAIL fill_valid c%0d: got %b required %b", c, bus.meirei_valid, (c >= 3));
      end
      if (c == 3) begin
        n_tests++;
        if (bus.meirei !== 16'hA000) begin n_fail++; $display("FAIL fill_meirei: got %h required A000", bus.meirei); end
        n_tests++;
        if (bus.meirei_pc !== 16'h0000) begin n_fail++; $display("FAIL fill_pc: got %h required 0000", bus.meirei_pc); end
      end
    end
    n_tests++;
    if (issue_cnt !== 4) begin n_fail++; $display("FAIL fill_reads: got %0d required 4", issue_cnt); end
  endtask

  task automatic test_take_stream();
    int ic;
    for (int k = 0; k < 6; k++) begin
      ic = issue_cnt;
      take_word();
      repeat (4) step();
      n_tests++;
      if (issue_cnt - ic !== 1) begin
        n_fail++;
        $display("FAIL refill_count take%0d: got %0d required 1", k, issue_cnt - ic);
      end
    end
  endtask

  task automatic test_redirect();
    take_word();
    go_edge();
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0040;
    exp_word_q.delete();
    next_fetch = 16'h0040;
    repeat (4) expect_fetch();
    sample();
    n_tests++;
    if (bus.imem_re !== 1'b0) begin n_fail++; $display("FAIL redir_suppress: re %b required 0", bus.imem_re); end
    go_edge();
    bus.redirect = 1'b0;
    sample();
    n_tests++;
    if (bus.meirei_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b required 0", bus.meirei_valid); end
    n_tests++;
    if (bus.imem_re !== 1'b0) begin n_fail++; $display("FAIL squash_re: got %b required 0", bus.imem_re); end
    step();
    n_tests++;
    if (bus.imem_re !== 1'b1 || bus.imem_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL redir_addr: re %b addr %h required re 1 addr 0040", bus.imem_re, bus.imem_addr);
    end
    step();
    n_tests++;
    if (bus.meirei_valid !== 1'b0) begin n_fail++; $display("FAIL redir_early: valid %b required 0", bus.meirei_valid); end
    step();
    n_tests++;
    if (bus.meirei_valid !== 1'b1 || bus.meirei_pc !== 16'h0040 || bus.meirei !== rom(16'h0040)) begin
      n_fail++;
      $display("FAIL redir_word: valid %b pc %h inst %h required 1 0040 %h",
               bus.meirei_valid, bus.meirei_pc, bus.meirei, rom(16'h0040));
    end
  endtask

  task automatic test_take_empty();
    repeat (3) step();
    go_edge();
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0080;
    exp_word_q.delete();
    next_fetch = 16'h0080;
    repeat (4) expect_fetch();
    sample();
    go_edge();
    bus.redirect = 1'b0;
    bus.take = 1'b1;
    sample();
    n_tests++;
    if (bus.meirei_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %b required 0", bus.meirei_valid); end
    n_tests++;
    if (bus.meirei !== rom(16'h0040) || bus.meirei_pc !== 16'h0040) begin
      n_fail++;
      $display("FAIL hold_last: inst %h pc %h required %h 0040", bus.meirei, bus.meirei_pc, rom(16'h0040));
    end
    step();
    go_edge();
    bus.take = 1'b0;
    sample();
    n_tests++;
    if (bus.meirei_valid !== 1'b1 || bus.meirei_pc !== 16'h0080 || bus.meirei !== rom(16'h0080)) begin
      n_fail++;
      $display("FAIL empty_take_ignored: valid %b pc %h inst %h required 1 0080 %h",
               bus.meirei_valid, bus.meirei_pc, bus.meirei, rom(16'h0080));
    end
    repeat (4) step();
    // take and redirect together: redirect wins, queue flushed.
    go_edge();
    bus.take = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    exp_word_q.delete();
    next_fetch = 16'hFFFE;
    repeat (4) expect_fetch();
    sample();
    n_tests++;
    if (bus.imem_re !== 1'b0) begin n_fail++; $display("FAIL tr_re: got %b required 0", bus.imem_re); end
    go_edge();
    bus.take = 1'b0;
    bus.redirect = 1'b0;
    sample();
    n_tests++;
    if (bus.meirei_valid !== 1'b0 || bus.meirei_pc !== 16'h0080) begin
      n_fail++;
      $display("FAIL tr_flush: valid %b pc %h required 0 0080", bus.meirei_valid, bus.meirei_pc);
    end
  endtask

  task automatic test_wrap();
    repeat (4) take_word();
  endtask

  task automatic test_reset_mid();
    take_word();
    go_edge();
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_re !== 1'b0 || bus.imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_rst_fetch: re %b addr %h required 0 0000", bus.imem_re, bus.imem_addr);
    end
    n_tests++;
    if (bus.meirei_valid !== 1'b0 || bus.meirei !== 16'h0000 || bus.meirei_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_rst_out: valid %b inst %h pc %h required 0 0000 0000",
               bus.meirei_valid, bus.meirei, bus.meirei_pc);
    end
    exp_addr_q.delete();
    exp_word_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    next_fetch = 16'h0000;
    repeat (4) expect_fetch();
    sample();
    n_tests++;
    if (bus.imem_re !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: re %b required 0", bus.imem_re); end
    step();
    n_tests++;
    if (bus.imem_re !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_rst_restart: re %b addr %h required 1 0000", bus.imem_re, bus.imem_addr);
    end
    repeat (2) take_word();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.take = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    next_fetch = 16'h0000;
    test_reset();
    test_fill();
    test_take_stream();
    test_redirect();
    test_take_empty();
    test_wrap();
    test_reset_mid();
    repeat (6) step();
    n_tests++;
    if (exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_reads: %0d reads never issued, required 0", exp_addr_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
